// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: register map, CTRL field positions and FSM state type for timer_counter
package timer_counter_pkg;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_e;
endpackage

// File: rtl/timer_counter_if.sv
// timer_counter_if: word-addressed register bus plus interrupt line of one timer
interface timer_counter_if;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer with maskable level interrupt
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);
  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;
  logic [1:0]  sel;
  logic        unused_addr;
  assign sel = bus.Addr[1:0];
  assign unused_addr = ^bus.Addr[29:2];
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    irq_d    = irq_q;
    if (bus.WE) begin
      // a write cycle freezes the state machine entirely
      if (sel == ADDR_CTRL)   ctrl_d   = bus.Din[3:0];
      if (sel == ADDR_PRESET) preset_d = bus.Din;
    end else begin
      case (state_q)
        IDLE: if (ctrl_q[CTRL_EN]) begin
          state_d = LOAD;
          irq_d   = 1'b0;
        end
        LOAD: begin
          count_d = preset_q;
          state_d = CNT;
        end
        CNT: if (!ctrl_q[CTRL_EN]) state_d = IDLE;
          else if (count_q > 32'd1) count_d = count_q - 32'd1;
          else begin
            count_d = '0;
            irq_d   = 1'b1;
            state_d = INT;
          end
        INT: begin
          // one-shot drops Enable and keeps the flag until software re-arms
          if (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == 2'b00) ctrl_d[CTRL_EN] = 1'b0;
          else irq_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end
  assign bus.Dout = sel == ADDR_CTRL   ? {28'd0, ctrl_q} :
                    sel == ADDR_PRESET ? preset_q :
                    sel == ADDR_COUNT  ? count_q : 32'd0;
  assign bus.IRQ  = ctrl_q[CTRL_IM] & irq_q;
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed scenarios plus random traffic checked against a behavioural timer model
module tb_timer_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  timer_counter_if bus();
  timer_counter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model: what the timer is doing, as plain variables
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_COUNT = 2, PH_FIRED = 3;
  int          m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  bit          m_flag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    return a == 2'd0 ? {28'd0, m_ctrl} : a == 2'd1 ? m_preset : a == 2'd2 ? m_count : 32'd0;
  endfunction

  function automatic void m_clear();
    m_phase = PH_IDLE; m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0;
  endfunction

  function automatic void m_tick(input bit we, input logic [1:0] a, input logic [31:0] d);
    bit en = m_ctrl[0];
    bit one_shot = (m_ctrl[2:1] == 2'b00);
    if (we) begin
      if (a == 2'd0) m_ctrl = d[3:0];
      if (a == 2'd1) m_preset = d;
      return;
    end
    if (m_phase == PH_IDLE && en) begin m_phase = PH_LOAD; m_flag = 0; end
    else if (m_phase == PH_LOAD) begin m_count = m_preset; m_phase = PH_COUNT; end
    else if (m_phase == PH_COUNT) begin
      if (!en) m_phase = PH_IDLE;
      else if (m_count > 1) m_count = m_count - 1;
      else begin m_count = 0; m_flag = 1; m_phase = PH_FIRED; end
    end else if (m_phase == PH_FIRED) begin
      if (one_shot) m_ctrl[0] = 1'b0; else m_flag = 0;
      m_phase = PH_IDLE;
    end
  endfunction

  // drive one cycle, check combinational outputs mid-cycle, then advance the model
  task automatic cyc(input bit rst, input bit we, input logic [1:0] a, input logic [31:0] d);
    reset = rst;
    bus.WE = we;
    bus.Addr = {28'($urandom), a};
    bus.Din = d;
    @(negedge clk);
    chk($sformatf("dout@%0d", a), bus.Dout, m_read(a));
    chk("irq", {31'd0, bus.IRQ}, {31'd0, m_ctrl[3] & m_flag});
    @(posedge clk);
    if (rst) m_clear(); else m_tick(we, a, d);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) cyc(0, 0, a, 32'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_clear();
    bus.WE = 0; bus.Addr = 0; bus.Din = 0;
    cyc(1, 0, 2'd0, 0);
    cyc(1, 1, 2'd1, 32'h1234);
    for (int i = 0; i < 20; i++) cyc(0, 0, 2'(i), 0);
    // one-shot
    cyc(0, 1, 2'd1, 5);
    cyc(0, 1, 2'd0, 32'h9);
    idle(2, 2'd2);
    for (int i = 5; i >= 0; i--) begin
      chk("oneshot_count", bus.Dout, 32'(i));
      idle(1, 2'd2);
    end
    idle(1, 2'd0);
    chk("oneshot_ctrl", bus.Dout, 32'h8);
    chk("oneshot_irq", {31'd0, bus.IRQ}, 32'd1);
    idle(5, 2'd0);
    cyc(0, 1, 2'd0, 32'h9);
    idle(3, 2'd2);
    cyc(0, 1, 2'd0, 32'h0);
    idle(2, 2'd0);
    // auto-reload over several periods
    cyc(0, 1, 2'd1, 3);
    cyc(0, 1, 2'd0, 32'hB);
    idle(20, 2'd2);
    cyc(0, 1, 2'd0, 32'h0);
    idle(3, 2'd2);
    // masked one-shot, then unmask
    cyc(0, 1, 2'd1, 2);
    cyc(0, 1, 2'd0, 32'h1);
    idle(8, 2'd2);
    cyc(0, 1, 2'd0, 32'h8);
    chk("unmask_irq", {31'd0, bus.IRQ}, 32'd1);
    idle(2, 2'd0);
    // pause by writing CTRL mid-count, ignored COUNT write, CTRL width
    cyc(0, 1, 2'd1, 20);
    cyc(0, 1, 2'd0, 32'h1);
    idle(6, 2'd2);
    cyc(0, 1, 2'd0, 32'h0);
    idle(4, 2'd2);
    cyc(0, 1, 2'd2, 32'hFFFF);
    idle(2, 2'd2);
    cyc(0, 1, 2'd0, 32'hFFFF_FFFF);
    idle(1, 2'd0);
    chk("ctrl_width", bus.Dout, 32'hF);
    // reset while counting at 7
    cyc(0, 1, 2'd0, 32'h0);
    idle(2, 2'd0);
    cyc(0, 1, 2'd1, 10);
    cyc(0, 1, 2'd0, 32'h9);
    for (int i = 0; i < 40 && !(m_phase == PH_COUNT && m_count == 7); i++) idle(1, 2'd2);
    chk("reached_7", bus.Dout, 32'd7);
    cyc(1, 0, 2'd2, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 2'(i), 0);
    // random traffic: occasional writes, small presets so interrupts happen often
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) cyc(1, 0, 2'($urandom), 0);
      cyc(0, 1, 2'd1, 32'($urandom_range(0, 8)));
      cyc(0, 1, 2'd0, 32'($urandom) | 32'h1);
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 14) == 0) begin
          logic [1:0] a = 2'($urandom);
          cyc(0, 1, a, a == 2'd0 ? 32'($urandom) : 32'($urandom_range(0, 8)));
        end else cyc(0, 0, 2'($urandom), 32'($urandom));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
